// File: rtl/uart_tx_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter_pkg
// Shared definitions for the UART transmit arbiter and its round-robin picker:
//   - default byte width (shared with uart_tx), requester count and hold timeout
//   - one-hot FSM state encoding
//   - width helpers for the round-robin pointer and the HOLD timeout counter
// No ports (package).
// -----------------------------------------------------------------------------
package uart_tx_arbiter_pkg;

   // Default byte width; must match the NB_DATA of the uart_tx being shared.
   localparam int NB_DATA_DEF      = 8;
   localparam int N_REQ_DEF        = 4;
   localparam int HOLD_TIMEOUT_DEF = 1024;

   // One-hot arbiter states.
   typedef enum logic [3:0] {
      S_IDLE  = 4'b0001,
      S_START = 4'b0010,
      S_WAIT  = 4'b0100,
      S_HOLD  = 4'b1000
   } arb_state_t;

   // Width of an index into n requesters (at least one bit).
   function automatic int ptr_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   // Width of the HOLD counter; it only has to reach timeout-1.
   function automatic int hold_cnt_w(input int timeout);
      return (timeout < 2) ? 1 : $clog2(timeout);
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Finds the first asserted request searching
// from i_ptr upward, wrapping modulo N_REQ. Reusable for any shared peripheral.
//
// Ports:
//   i_req    in   N_REQ  request vector
//   i_ptr    in   PTR_W  index that has highest priority this cycle
//   o_grant  out  N_REQ  one-hot winner (all zero when nothing requests)
//   o_idx    out  PTR_W  binary index of the winner (0 when nothing requests)
//   o_found  out  1      at least one request was present
// -----------------------------------------------------------------------------
module rr_pick
   import uart_tx_arbiter_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int PTR_W = ptr_w(N_REQ)
) (
   input  logic [N_REQ-1:0] i_req,
   input  logic [PTR_W-1:0] i_ptr,
   output logic [N_REQ-1:0] o_grant,
   output logic [PTR_W-1:0] o_idx,
   output logic             o_found
);

   // One extra bit holds ptr+i before the modulo fold (max 2*N_REQ-2).
   logic [PTR_W:0]   w_pos;
   logic [PTR_W-1:0] w_idx;

   always_comb begin
      // NOTE: every variable driven here gets a default before the loop, so no
      // path leaves it unassigned and no latch is inferred.
      o_grant = '0;
      o_idx   = '0;
      o_found = 1'b0;
      w_pos   = '0;
      w_idx   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         w_pos = {1'b0, i_ptr} + (PTR_W+1)'(i);
         if (w_pos >= (PTR_W+1)'(N_REQ)) begin
            w_pos = w_pos - (PTR_W+1)'(N_REQ);
         end
         w_idx = w_pos[PTR_W-1:0];
         // First hit in search order wins; later hits are ignored.
         if (!o_found && i_req[w_idx]) begin
            o_grant[w_idx] = 1'b1;
            o_idx          = w_idx;
            o_found        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one uart_tx serializer between N_REQ byte producers. Grants are
// round-robin; each accepted byte produces exactly one start pulse and the
// arbiter waits for the matching done pulse before the next byte. A requester
// keeps the grant across a multi-byte message until it marks the last byte;
// a stalled lock is released after HOLD_TIMEOUT idle cycles in HOLD.
//
// Ports:
//   clk             in   1              system clock
//   i_reset         in   1              synchronous, active-high reset
//   i_req_valid     in   N_REQ          per-requester byte valid
//   i_req_data      in   N_REQ*NB_DATA  requester k byte at [k*NB_DATA +: NB_DATA]
//   i_req_last      in   N_REQ          byte ends that requester's message
//   o_req_ready     out  N_REQ          accept strobe (transfer = valid & ready)
//   o_tx_start      out  1              one-cycle start pulse to uart_tx
//   o_tx_data       out  NB_DATA        byte to uart_tx, held between bytes
//   i_tx_done       in   1              uart_tx done pulse (used only in WAIT)
//   o_grant         out  N_REQ          one-hot current owner, 0 when IDLE
//   o_busy          out  1              high in every state except IDLE
//   o_lock_timeout  out  1              one-cycle pulse when a HOLD lock expires
// -----------------------------------------------------------------------------
module uart_tx_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter int NB_DATA      = NB_DATA_DEF,
   parameter int N_REQ        = N_REQ_DEF,
   parameter int HOLD_TIMEOUT = HOLD_TIMEOUT_DEF
) (
   input  logic                     clk,
   input  logic                     i_reset,
   input  logic [N_REQ-1:0]         i_req_valid,
   input  logic [N_REQ*NB_DATA-1:0] i_req_data,
   input  logic [N_REQ-1:0]         i_req_last,
   output logic [N_REQ-1:0]         o_req_ready,
   output logic                     o_tx_start,
   output logic [NB_DATA-1:0]       o_tx_data,
   input  logic                     i_tx_done,
   output logic [N_REQ-1:0]         o_grant,
   output logic                     o_busy,
   output logic                     o_lock_timeout
);

   localparam int PTR_W = ptr_w(N_REQ);
   localparam int CNT_W = hold_cnt_w(HOLD_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_TIMEOUT - 1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);

   // ---------------------------------------------------------------- state
   arb_state_t         r_state;
   logic [PTR_W-1:0]   r_rr_ptr;      // highest-priority requester in IDLE
   logic [PTR_W-1:0]   r_owner;       // binary index of the current owner
   logic [N_REQ-1:0]   r_grant;       // one-hot copy of r_owner, 0 when free
   logic [NB_DATA-1:0] r_tx_data;     // byte presented to uart_tx
   logic               r_last;        // captured byte closes the message
   logic               r_tx_start;
   logic               r_lock_timeout;
   logic [CNT_W-1:0]   r_hold_cnt;

   // ---------------------------------------------------------------- wires
   logic [N_REQ-1:0]   w_win_grant;
   logic [PTR_W-1:0]   w_win_idx;
   logic               w_win_found;
   logic [PTR_W-1:0]   w_sel_idx;
   logic [NB_DATA-1:0] w_sel_data;
   logic               w_sel_last;
   logic [N_REQ-1:0]   w_req_ready;
   logic               w_owner_valid;
   logic [PTR_W-1:0]   w_next_ptr;

   rr_pick #(
      .N_REQ (N_REQ),
      .PTR_W (PTR_W)
   ) u_rr_pick (
      .i_req   (i_req_valid),
      .i_ptr   (r_rr_ptr),
      .o_grant (w_win_grant),
      .o_idx   (w_win_idx),
      .o_found (w_win_found)
   );

   // In HOLD only the locked owner may feed a byte; in IDLE the picker decides.
   assign w_sel_idx     = (r_state == S_HOLD) ? r_owner : w_win_idx;
   assign w_owner_valid = |(r_grant & i_req_valid);

   // Pointer moves past the owner only when its message ends or its lock expires.
   assign w_next_ptr = (r_owner == PTR_LAST) ? '0 : r_owner + 1'b1;

   // Mux the selected requester's byte and last flag.
   always_comb begin
      w_sel_data = '0;
      w_sel_last = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         if (w_sel_idx == PTR_W'(k)) begin
            w_sel_data = i_req_data[k*NB_DATA +: NB_DATA];
            w_sel_last = i_req_last[k];
         end
      end
   end

   // Ready is combinational so a valid seen in IDLE is accepted the same cycle.
   // Both sources are already masked by valid, so ready never fires alone.
   always_comb begin
      w_req_ready = '0;
      if (r_state == S_IDLE) begin
         w_req_ready = w_win_grant;
      end else if (r_state == S_HOLD) begin
         w_req_ready = r_grant & i_req_valid;
      end
   end

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      // NOTE: all state here uses non-blocking (<=) so every register samples
      // the pre-edge values and the update order inside the block is irrelevant.
      if (i_reset) begin
         r_state        <= S_IDLE;
         r_rr_ptr       <= '0;
         r_owner        <= '0;
         r_grant        <= '0;
         r_tx_data      <= '0;
         r_last         <= 1'b0;
         r_tx_start     <= 1'b0;
         r_lock_timeout <= 1'b0;
         r_hold_cnt     <= '0;
      end else begin
         // Pulses default low; only the branches below raise them for a cycle.
         r_tx_start     <= 1'b0;
         r_lock_timeout <= 1'b0;

         unique case (r_state)
            S_IDLE: begin
               if (w_win_found) begin
                  r_tx_data  <= w_sel_data;
                  r_last     <= w_sel_last;
                  r_owner    <= w_win_idx;
                  r_grant    <= w_win_grant;
                  r_tx_start <= 1'b1;
                  r_state    <= S_START;
               end
            end

            // r_tx_start is high for exactly this state.
            S_START: begin
               r_state <= S_WAIT;
            end

            // Done pulses are honoured only here, so strays elsewhere are inert.
            S_WAIT: begin
               if (i_tx_done) begin
                  if (r_last) begin
                     r_rr_ptr <= w_next_ptr;
                     r_grant  <= '0;
                     r_state  <= S_IDLE;
                  end else begin
                     r_hold_cnt <= '0;
                     r_state    <= S_HOLD;
                  end
               end
            end

            S_HOLD: begin
               if (w_owner_valid) begin
                  r_tx_data  <= w_sel_data;
                  r_last     <= w_sel_last;
                  r_tx_start <= 1'b1;
                  r_state    <= S_START;
               end else if (r_hold_cnt == CNT_LAST) begin
                  r_lock_timeout <= 1'b1;
                  r_rr_ptr       <= w_next_ptr;
                  r_grant        <= '0;
                  r_state        <= S_IDLE;
               end else begin
                  r_hold_cnt <= r_hold_cnt + 1'b1;
               end
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------- outputs
   assign o_req_ready    = w_req_ready;
   assign o_tx_start     = r_tx_start;
   assign o_tx_data      = r_tx_data;
   assign o_grant        = r_grant;
   assign o_busy         = (r_state != S_IDLE);
   assign o_lock_timeout = r_lock_timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Directed bench for uart_tx_arbiter (N_REQ=4, NB_DATA=8, HOLD_TIMEOUT=16).
// Producers are per-requester byte queues; a small uart_tx model answers each
// start with a done pulse a fixed number of cycles later (or is driven by hand).
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

   localparam int NB_DATA  = 8;
   localparam int N_REQ    = 4;
   localparam int HOLD_TO  = 16;
   localparam int DONE_DLY = 3;
   localparam int QDEPTH   = 16;
   localparam int MAX_RUN  = 300;

   logic                     clk = 1'b0;
   logic                     i_reset = 1'b1;
   logic [N_REQ-1:0]         i_req_valid = '0;
   logic [N_REQ*NB_DATA-1:0] i_req_data = '0;
   logic [N_REQ-1:0]         i_req_last = '0;
   logic [N_REQ-1:0]         o_req_ready;
   logic                     o_tx_start;
   logic [NB_DATA-1:0]       o_tx_data;
   logic                     i_tx_done = 1'b0;
   logic [N_REQ-1:0]         o_grant;
   logic                     o_busy;
   logic                     o_lock_timeout;

   uart_tx_arbiter #(
      .NB_DATA      (NB_DATA),
      .N_REQ        (N_REQ),
      .HOLD_TIMEOUT (HOLD_TO)
   ) dut (
      .clk            (clk),
      .i_reset        (i_reset),
      .i_req_valid    (i_req_valid),
      .i_req_data     (i_req_data),
      .i_req_last     (i_req_last),
      .o_req_ready    (o_req_ready),
      .o_tx_start     (o_tx_start),
      .o_tx_data      (o_tx_data),
      .i_tx_done      (i_tx_done),
      .o_grant        (o_grant),
      .o_busy         (o_busy),
      .o_lock_timeout (o_lock_timeout)
   );

   always #5 clk = ~clk;

   // ---------------------------------------------------------------- bookkeeping
   int n_total = 0;
   int n_bad   = 0;

   logic [8:0] q_mem [N_REQ][QDEPTH];   // {last, data}
   int         q_head [N_REQ];
   int         q_tail [N_REQ];

   logic [11:0] start_log [$];           // {grant, data} per start
   int          gap_log [$];             // cycles since the previous done
   int  cyc           = 0;
   int  last_done_cyc = 0;
   int  to_gap        = 0;
   int  n_timeouts    = 0;
   int  n_overlap     = 0;
   int  n_starts      = 0;
   int  n_dones       = 0;
   int  uart_cnt      = 0;
   bit  uart_busy     = 1'b0;
   bit  auto_done     = 1'b1;
   bit  watch_on      = 1'b0;
   bit  watch_viol    = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_reqs();
      for (int k = 0; k < N_REQ; k++) begin
         if (q_tail[k] > q_head[k]) begin
            i_req_valid[k]               = 1'b1;
            i_req_data[k*NB_DATA +: NB_DATA] = q_mem[k][q_head[k]][7:0];
            i_req_last[k]                = q_mem[k][q_head[k]][8];
         end else begin
            i_req_valid[k] = 1'b0;
         end
      end
   endtask

   task automatic push(input int k, input logic [7:0] d, input logic last);
      q_mem[k][q_tail[k]] = {last, d};
      q_tail[k]++;
      drive_reqs();
   endtask

   // One clock: sample this cycle, advance the edge, drive the next cycle.
   task automatic cycle();
      logic [N_REQ-1:0] pop;
      #1;
      pop = i_req_valid & o_req_ready;
      if (watch_on && (q_tail[2] > q_head[2]) && o_req_ready[0]) watch_viol = 1'b1;
      if (o_lock_timeout) begin
         n_timeouts++;
         to_gap = cyc - last_done_cyc;
      end
      if (i_tx_done) begin
         last_done_cyc = cyc;
         if (uart_busy) begin
            uart_busy = 1'b0;
            n_dones++;
         end
      end
      if (o_tx_start) begin
         if (uart_busy) n_overlap++;
         n_starts++;
         start_log.push_back({o_grant, o_tx_data});
         gap_log.push_back(cyc - last_done_cyc);
         uart_busy = 1'b1;
         uart_cnt  = DONE_DLY;
      end
      @(posedge clk);
      #1;
      cyc++;
      for (int k = 0; k < N_REQ; k++) begin
         if (pop[k]) q_head[k]++;
      end
      drive_reqs();
      if (auto_done) begin
         i_tx_done = uart_busy && (uart_cnt == 0);
         if (uart_busy && uart_cnt > 0) uart_cnt--;
      end
      #1;
   endtask

   task automatic run_until_idle(input string tag);
      int k;
      k = 0;
      cycle();
      while ((o_busy || (|i_req_valid) || uart_busy) && k < MAX_RUN) begin
         cycle();
         k++;
      end
      check(tag, (k < MAX_RUN), 1'b1);
   endtask

   task automatic check_reset_outputs();
      check("rst_grant",   o_grant,        4'b0000);
      check("rst_busy",    o_busy,         1'b0);
      check("rst_start",   o_tx_start,     1'b0);
      check("rst_data",    o_tx_data,      8'h00);
      check("rst_timeout", o_lock_timeout, 1'b0);
      check("rst_ready",   o_req_ready,    4'b0000);
      check("rst_rr_ptr",  dut.r_rr_ptr,   2'd0);
   endtask

   task automatic clear_logs();
      start_log.delete();
      gap_log.delete();
   endtask

   // ---------------------------------------------------------------- stimulus
   initial begin
      for (int k = 0; k < N_REQ; k++) begin
         q_head[k] = 0;
         q_tail[k] = 0;
      end

      // ---- reset and single byte from requester 0
      i_reset = 1'b1;
      cycle();
      cycle();
      check_reset_outputs();
      i_reset = 1'b0;
      push(0, 8'hA5, 1'b1);
      #1;
      check("t1_ready_same_cycle", o_req_ready, 4'b0001);
      cycle();
      check("t1_start_next_cycle", o_tx_start, 1'b1);
      check("t1_tx_data",          o_tx_data,  8'hA5);
      check("t1_grant",            o_grant,    4'b0001);
      run_until_idle("t1_finish");
      check("t1_grant_idle", o_grant,      4'b0000);
      check("t1_busy_idle",  o_busy,       1'b0);
      check("t1_rr_ptr",     dut.r_rr_ptr, 2'd1);

      // Single byte from requester 3 wraps the pointer back to 0.
      push(3, 8'hEE, 1'b1);
      run_until_idle("t1b_finish");
      check("t1b_rr_wrap", dut.r_rr_ptr, 2'd0);

      // ---- all four requesters at once
      clear_logs();
      n_starts = 0;
      n_dones  = 0;
      for (int k = 0; k < N_REQ; k++) push(k, 8'h10 + 8'(k), 1'b1);
      run_until_idle("t2_finish");
      check("t2_n_starts", start_log.size(), 4);
      check("t2_start0", start_log[0], {4'b0001, 8'h10});
      check("t2_start1", start_log[1], {4'b0010, 8'h11});
      check("t2_start2", start_log[2], {4'b0100, 8'h12});
      check("t2_start3", start_log[3], {4'b1000, 8'h13});
      check("t2_gap1", gap_log[1], 2);
      check("t2_gap2", gap_log[2], 2);
      check("t2_gap3", gap_log[3], 2);
      check("t2_start_eq_done", n_starts, n_dones);
      check("t2_rr_ptr", dut.r_rr_ptr, 2'd0);

      // ---- locked 3-byte message from requester 2, requester 0 waiting
      clear_logs();
      push(2, 8'h01, 1'b0);
      push(2, 8'h02, 1'b0);
      push(2, 8'h03, 1'b1);
      cycle();
      push(0, 8'h55, 1'b1);
      watch_on = 1'b1;
      run_until_idle("t3_finish");
      watch_on = 1'b0;
      check("t3_n_starts", start_log.size(), 4);
      check("t3_byte0", start_log[0], {4'b0100, 8'h01});
      check("t3_byte1", start_log[1], {4'b0100, 8'h02});
      check("t3_byte2", start_log[2], {4'b0100, 8'h03});
      check("t3_req0_next", start_log[3], {4'b0001, 8'h55});
      check("t3_gap_hold1", gap_log[1], 2);
      check("t3_gap_hold2", gap_log[2], 2);
      check("t3_gap_after", gap_log[3], 2);
      check("t3_req0_ready_in_lock", watch_viol, 1'b0);
      check("t3_rr_ptr", dut.r_rr_ptr, 2'd1);

      // ---- lock timeout: requester 1 stalls after a non-last byte
      clear_logs();
      n_timeouts = 0;
      push(1, 8'h77, 1'b0);
      push(3, 8'h33, 1'b1);
      run_until_idle("t4_finish");
      check("t4_n_timeouts", n_timeouts, 1);
      check("t4_timeout_delay", to_gap, HOLD_TO + 1);
      check("t4_n_starts", start_log.size(), 2);
      check("t4_byte", start_log[0], {4'b0010, 8'h77});
      check("t4_req3_next", start_log[1], {4'b1000, 8'h33});
      check("t4_rr_ptr", dut.r_rr_ptr, 2'd0);

      // ---- spurious done in IDLE and HOLD
      clear_logs();
      auto_done = 1'b0;
      i_tx_done = 1'b1;
      cycle();
      i_tx_done = 1'b0;
      cycle();
      check("t5_idle_busy",  o_busy,           1'b0);
      check("t5_idle_grant", o_grant,          4'b0000);
      check("t5_idle_nostart", start_log.size(), 0);
      push(0, 8'h40, 1'b0);
      cycle();
      cycle();
      i_tx_done = 1'b1;
      cycle();
      i_tx_done = 1'b0;
      i_tx_done = 1'b1;
      cycle();
      i_tx_done = 1'b0;
      cycle();
      check("t5_hold_start", o_tx_start,       1'b0);
      check("t5_hold_busy",  o_busy,           1'b1);
      check("t5_hold_grant", o_grant,          4'b0001);
      check("t5_hold_nostart", start_log.size(), 1);
      push(0, 8'h41, 1'b1);
      auto_done = 1'b1;
      run_until_idle("t5_finish");
      check("t5_n_starts", start_log.size(), 2);
      check("t5_release_byte", start_log[1], {4'b0001, 8'h41});
      check("t5_no_overlap", n_overlap, 0);

      // ---- reset in WAIT, then reset in HOLD
      auto_done = 1'b0;
      push(2, 8'h99, 1'b0);
      cycle();
      cycle();
      check("t6_in_wait_busy", o_busy, 1'b1);
      i_reset = 1'b1;
      cycle();
      check_reset_outputs();
      i_reset   = 1'b0;
      uart_busy = 1'b0;
      push(2, 8'h9A, 1'b0);
      cycle();
      cycle();
      i_tx_done = 1'b1;
      cycle();
      i_tx_done = 1'b0;
      cycle();
      check("t6_in_hold_grant", o_grant, 4'b0100);
      i_reset = 1'b1;
      cycle();
      check_reset_outputs();
      check("t6_hold_cnt_reset", dut.r_hold_cnt, 4'd0);
      i_reset = 1'b0;
      clear_logs();
      push(3, 8'hC3, 1'b1);
      push(0, 8'hC0, 1'b1);
      auto_done = 1'b1;
      run_until_idle("t6_finish");
      check("t6_n_starts", start_log.size(), 2);
      check("t6_first_idx0", start_log[0], {4'b0001, 8'hC0});
      check("t6_then_idx3",  start_log[1], {4'b1000, 8'hC3});
      check("t6_no_overlap", n_overlap, 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   // Global time limit so the bench always terminates.
   initial begin
      #200000;
      $display("FAIL global_timeout: observed=stuck expected=finish");
      $fatal(1, "time limit reached");
   end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one uart_tx serializer between N_REQ byte producers, for example a command-response path, a debug dump and a status reporter. Producers use a valid/ready byte handshake. The arbiter grants round-robin, issues one start pulse per byte to uart_tx, and waits for its done pulse before sending the next byte. A requester may lock the grant across a multi-byte message until it marks the last byte, with a timeout that releases a stalled lock.

Parameters:
NB_DATA, 8, byte width; must match uart_tx NB_DATA
N_REQ, 4, number of requesters (2..8)
HOLD_TIMEOUT, 1024, cycles a locked grant waits in HOLD for the owner's next byte before releasing (>=2)

Ports:
clk  in  1  system clock
i_reset  in  1  synchronous, active-high reset
i_req_valid  in  N_REQ  per-requester byte valid
i_req_data  in  N_REQ*NB_DATA  requester k byte in bits [k*NB_DATA +: NB_DATA]
i_req_last  in  N_REQ  byte is the final byte of that requester's message
o_req_ready  out  N_REQ  accept strobe; a transfer occurs when valid&ready
o_tx_start  out  1  one-cycle start pulse to uart_tx i_start_tx
o_tx_data  out  NB_DATA  byte to uart_tx i_data; stable while o_tx_start=1
i_tx_done  in  1  uart_tx o_txdone pulse
o_grant  out  N_REQ  one-hot current owner; 0 when IDLE
o_busy  out  1  high in every state except IDLE
o_lock_timeout  out  1  one-cycle pulse when a HOLD lock expires

Behaviour:
- Reset values: state=IDLE; rr_ptr=0; o_tx_start=0; o_tx_data=0; o_grant=0; o_req_ready=0; o_busy=0; o_lock_timeout=0; hold counter=0. Reset is legal in any state. uart_tx shares the reset, so no pending done is tracked across reset.
- States (one-hot): IDLE, START, WAIT, HOLD.
- IDLE:
  - winner w = first index with valid=1, searching rr_ptr, rr_ptr+1, ... modulo N_REQ.
  - o_req_ready[w]=1 combinationally in the same cycle.
  - Capture data into tx_reg and last into last_reg; register o_grant=onehot(w).
  - Next state is START.
  - No valid means stay in IDLE.
- START:
  - o_tx_start=1 for exactly this cycle; o_tx_data=tx_reg.
  - Next state is WAIT.
- WAIT:
  - Stay until i_tx_done=1.
  - On done with last_reg=1: rr_ptr=(w+1) mod N_REQ, o_grant=0, next state is IDLE.
  - On done with last_reg=0: clear the hold counter, next state is HOLD.
- HOLD:
  - Only the owner w is eligible; o_req_ready[w]=valid[w]. All other valids are ignored.
  - Owner valid means capture and go to START, as in IDLE.
  - Otherwise the counter increments each cycle. When counter==HOLD_TIMEOUT-1: pulse o_lock_timeout, rr_ptr=(w+1) mod N_REQ, o_grant=0, next state is IDLE.
- o_tx_data holds tx_reg between bytes; it is not cleared.
- i_tx_done outside WAIT is ignored.
- Exactly one o_tx_start per i_tx_done. No start is ever issued while uart_tx is busy.
- Latency:
  - valid high in IDLE at cycle t gives ready at t and start at t+1.
  - done at cycle d gives the earliest next acceptance at d+1 and the next start at d+2.
- Valid must stay high with stable data/last until ready. Ready is never asserted without valid.
- Simultaneous requests: the lowest index at or after rr_ptr wins.
- rr_ptr wraps N_REQ-1 to 0.
- rr_ptr advances only when a message ends (last byte done) or a lock times out.

Decomposition:
- Shared header (uart_arb_defs): one-hot state localparams, the HOLD counter width clog2(HOLD_TIMEOUT), and the NB_DATA default shared with uart_tx.
- One sub-module, rr_pick: combinational, inputs request vector and pointer, outputs one-hot winner and a found flag. It is reused later for other shared peripherals.

Test Plan:
- Reset, then i_req_valid=4'b0001, data 8'hA5, last=1.
  - ready[0] pulses the same cycle; o_tx_start one cycle later with o_tx_data=8'hA5.
  - After the model asserts done: o_grant=0, o_busy=0, rr_ptr=1.
- With rr_ptr=0, all four valid with data 8'h10..8'h13, last=1, held until served.
  - Start order is 8'h10, 8'h11, 8'h12, 8'h13.
  - Exactly one start per done; rr_ptr returns to 0.
- Requester 2 sends 3 bytes 8'h01, 8'h02, 8'h03 with last only on the third, while requester 0 is valid throughout.
  - Three consecutive starts all carry o_grant=4'b0100.
  - Requester 0 is served next; its ready is never high during the lock.
- Requester 1 sends one byte with last=0, then drops valid, with HOLD_TIMEOUT=16.
  - o_lock_timeout pulses 16 cycles after entering HOLD.
  - State returns to IDLE; a pending requester 3 is granted next.
- Spurious i_tx_done in IDLE and HOLD causes no state change and no start.
  - Back-to-back: a done at cycle d gives the next start exactly at d+2.
- Assert i_reset in WAIT and again in HOLD.
  - The next cycle shows all outputs at reset values.
  - After release, a new request is served starting from index 0.
